// File: rtl/lms_pcm_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : lms_pcm_tx_if
// Description : Sample-write and serial PCM signal bundle for lms_pcm_tx.
//               The master side writes samples and controls framing; the slave
//               side (the transmitter) drives the serial and status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface lms_pcm_tx_if #(
    parameter int W     = 16,
    parameter int DEPTH = 4
);
    logic                   en;
    logic [W-1:0]           din;
    logic                   din_vld;
    logic                   clr_ovf;
    logic                   bclk;
    logic                   sdata;
    logic                   fs;
    logic                   busy;
    logic                   ovf;
    logic [$clog2(DEPTH):0] level;

    modport master (
        output en, din, din_vld, clr_ovf,
        input  bclk, sdata, fs, busy, ovf, level
    );

    modport slave (
        input  en, din, din_vld, clr_ovf,
        output bclk, sdata, fs, busy, ovf, level
    );
endinterface
`default_nettype wire

// File: rtl/lms_pcm_tx.sv
`default_nettype none
// ============================================================================
// Module      : lms_pcm_tx
// Description : Buffers filtered LMS samples in a small FIFO and shifts them
//               out MSB first as PCM frames with bit clock and frame sync.
// Revision    : 1.0 - initial release
// ============================================================================
module lms_pcm_tx #(
    parameter int W      = 16,
    parameter int DEPTH  = 4,
    parameter int CLKDIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    lms_pcm_tx_if.slave  pcm
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKDIV);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKDIV / 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;
    logic          ovf_q;
    logic          ovf_d;

    // Serializer state
    state_t        state_q;
    logic [W-1:0]  sr_q;
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] idx_q;
    logic          bclk_q;
    logic          sdata_q;
    logic          fs_q;
    logic          busy_q;

    logic          full;
    logic          not_empty;
    logic          frame_end;
    logic          pop;
    logic          push;
    logic [CW-1:0] cnt_nxt;
    logic [W-1:0]  sr_shift;
    logic [W-1:0]  head;

    // Pop/push arbitration: a pop in the same cycle frees the slot for a write
    always_comb begin
        not_empty = (level_q != '0);
        full      = (level_q == LVL_FULL);
        frame_end = (state_q == SHIFT) && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
        pop       = pcm.en && not_empty && ((state_q == IDLE) || frame_end);
        push      = pcm.din_vld && (!full || pop);
        level_d   = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
        cnt_nxt   = cnt_q + CW'(1);
        sr_shift  = sr_q << 1;
        head      = mem_q[rd_ptr_q];
        ovf_d     = ovf_q;
        if (pcm.clr_ovf) begin
            ovf_d = 1'b0;
        end
        // A new drop wins over a simultaneous clear
        if (pcm.din_vld && !push) begin
            ovf_d = 1'b1;
        end
    end

    // Sample storage: contents need no reset, the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pcm.din;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    // Frame FSM with registered serial outputs; a pop always (re)starts a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            bclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else if (pop) begin
            state_q <= SHIFT;
            sr_q    <= head;
            cnt_q   <= '0;
            idx_q   <= '0;
            bclk_q  <= 1'b0;
            sdata_q <= head[W-1];
            fs_q    <= 1'b1;
            busy_q  <= 1'b1;
        end else if (state_q == SHIFT) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q  <= '0;
                bclk_q <= 1'b0;
                fs_q   <= 1'b0;
                if (idx_q == IDX_LAST) begin
                    state_q <= IDLE;
                    sr_q    <= '0;
                    idx_q   <= '0;
                    sdata_q <= 1'b0;
                    busy_q  <= 1'b0;
                end else begin
                    idx_q   <= idx_q + IW'(1);
                    sr_q    <= sr_shift;
                    sdata_q <= sr_shift[W-1];
                end
            end else begin
                cnt_q  <= cnt_nxt;
                bclk_q <= (cnt_nxt >= CNT_HALF);
            end
        end
    end

    assign pcm.bclk  = bclk_q;
    assign pcm.sdata = sdata_q;
    assign pcm.fs    = fs_q;
    assign pcm.busy  = busy_q;
    assign pcm.ovf   = ovf_q;
    assign pcm.level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_lms_pcm_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_lms_pcm_tx
// Description : Directed self-checking bench for lms_pcm_tx (W=16, DEPTH=4,
//               CLKDIV=4): single frame, back-to-back frames, overflow,
//               full-FIFO write/pop collision, en gating and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lms_pcm_tx;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   inj_idx;
    logic [15:0] inj_data;

    lms_pcm_tx_if #(.W(16), .DEPTH(4)) pcm_if ();

    lms_pcm_tx #(.W(16), .DEPTH(4), .CLKDIV(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pcm   (pcm_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [15:0] d);
        pcm_if.din     = d;
        pcm_if.din_vld = 1'b1;
        tick();
    endtask

    // Walks one frame from cycle 'start' (0 = first fs cycle) to its end and
    // checks data bits (sampled mid-bit), fs placement, bclk shape and busy.
    // If inj_idx matches a cycle, a write of inj_data is driven on that edge.
    task automatic run_frame(input string tag, input logic [15:0] exp, input int start);
        logic [15:0] word;
        logic [15:0] mask;
        int          fsn;
        int          berr;
        logic        prev;
        word = '0;
        mask = '0;
        fsn  = 0;
        berr = 0;
        prev = pcm_if.sdata;
        for (int i = 0; i < 64; i++) begin
            if (i >= start) begin
                if (i % 4 == 2) begin
                    word = {word[14:0], pcm_if.sdata};
                    mask = {mask[14:0], 1'b1};
                end
                if (pcm_if.fs) fsn++;
                if (pcm_if.fs !== (i < 4)) berr++;
                if (pcm_if.bclk !== ((i % 4) >= 2)) berr++;
                if (pcm_if.busy !== 1'b1) berr++;
                if (i > start && (i % 4) != 0 && pcm_if.sdata !== prev) berr++;
                prev = pcm_if.sdata;
                pcm_if.din_vld = (i == inj_idx);
                pcm_if.din     = inj_data;
                tick();
            end else if (i % 4 == 2) begin
                word = {word[14:0], 1'b0};
                mask = {mask[14:0], 1'b0};
            end
        end
        pcm_if.din_vld = 1'b0;
        chk({tag, ".data"}, 32'(word & mask), 32'(exp & mask));
        chk({tag, ".fs_cycles"}, fsn, (start < 4) ? (4 - start) : 0);
        chk({tag, ".shape_errs"}, berr, 0);
    endtask

    initial begin
        int errs;
        n_chk          = 0;
        n_fail         = 0;
        inj_idx        = -1;
        inj_data       = '0;
        rst_n          = 1'b0;
        pcm_if.en      = 1'b0;
        pcm_if.din     = '0;
        pcm_if.din_vld = 1'b0;
        pcm_if.clr_ovf = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst.busy", pcm_if.busy, 0);
        chk("rst.fs", pcm_if.fs, 0);
        chk("rst.bclk", pcm_if.bclk, 0);
        chk("rst.sdata", pcm_if.sdata, 0);
        chk("rst.ovf", pcm_if.ovf, 0);
        chk("rst.level", pcm_if.level, 0);
        rst_n = 1'b1;
        tick();

        // Single frame A5C3: popped one edge after acceptance
        pcm_if.en = 1'b1;
        put(16'hA5C3);
        pcm_if.din_vld = 1'b0;
        chk("t1.level", pcm_if.level, 1);
        chk("t1.busy_pre", pcm_if.busy, 0);
        tick();
        run_frame("t1", 16'hA5C3, 0);
        chk("t1.idle", pcm_if.busy, 0);

        // Four back-to-back frames
        put(16'h8001);
        chk("t2.level0", pcm_if.level, 1);
        put(16'h7FFE);
        put(16'hFFFF);
        put(16'h0000);
        pcm_if.din_vld = 1'b0;
        chk("t2.level_peak", pcm_if.level, 3);
        run_frame("t2a", 16'h8001, 2);
        run_frame("t2b", 16'h7FFE, 0);
        run_frame("t2c", 16'hFFFF, 0);
        run_frame("t2d", 16'h0000, 0);
        chk("t2.idle", pcm_if.busy, 0);
        chk("t2.ovf", pcm_if.ovf, 0);
        chk("t2.level_end", pcm_if.level, 0);

        // Six writes into a depth-4 FIFO: 6th dropped, ovf sticky until cleared
        for (int k = 1; k <= 6; k++) put(16'(k));
        pcm_if.din_vld = 1'b0;
        chk("t3.level", pcm_if.level, 4);
        chk("t3.ovf_set", pcm_if.ovf, 1);
        tick();
        chk("t3.ovf_hold", pcm_if.ovf, 1);
        pcm_if.clr_ovf = 1'b1;
        tick();
        pcm_if.clr_ovf = 1'b0;
        chk("t3.ovf_clr", pcm_if.ovf, 0);
        run_frame("t3a", 16'h0001, 6);
        run_frame("t3b", 16'h0002, 0);
        run_frame("t3c", 16'h0003, 0);
        run_frame("t3d", 16'h0004, 0);
        run_frame("t3e", 16'h0005, 0);
        chk("t3.idle", pcm_if.busy, 0);
        chk("t3.level_end", pcm_if.level, 0);

        // Full FIFO, write coinciding with the frame-boundary pop
        put(16'h1111);
        put(16'h2222);
        put(16'h3333);
        put(16'h4444);
        put(16'h5555);
        pcm_if.din_vld = 1'b0;
        chk("t4.full", pcm_if.level, 4);
        inj_idx  = 63;
        inj_data = 16'h6666;
        run_frame("t4a", 16'h1111, 3);
        inj_idx = -1;
        chk("t4.level_same", pcm_if.level, 4);
        chk("t4.ovf", pcm_if.ovf, 0);
        run_frame("t4b", 16'h2222, 0);
        run_frame("t4c", 16'h3333, 0);
        run_frame("t4d", 16'h4444, 0);
        run_frame("t4e", 16'h5555, 0);
        run_frame("t4f", 16'h6666, 0);
        chk("t4.idle", pcm_if.busy, 0);

        // en gating
        pcm_if.en = 1'b0;
        put(16'hC0DE);
        put(16'h1234);
        pcm_if.din_vld = 1'b0;
        errs = 0;
        for (int k = 0; k < 5; k++) begin
            if (pcm_if.busy !== 1'b0 || pcm_if.fs !== 1'b0) errs++;
            tick();
        end
        chk("t5.blocked", errs, 0);
        chk("t5.level2", pcm_if.level, 2);
        pcm_if.en = 1'b1;
        tick();
        chk("t5.start_fs", pcm_if.fs, 1);
        pcm_if.en = 1'b0;
        run_frame("t5a", 16'hC0DE, 0);
        errs = 0;
        for (int k = 0; k < 5; k++) begin
            if (pcm_if.busy !== 1'b0 || pcm_if.fs !== 1'b0) errs++;
            tick();
        end
        chk("t5.no_next", errs, 0);
        chk("t5.level1", pcm_if.level, 1);
        pcm_if.en = 1'b1;
        tick();
        chk("t5.restart_fs", pcm_if.fs, 1);
        run_frame("t5b", 16'h1234, 0);
        chk("t5.idle", pcm_if.busy, 0);

        // Asynchronous reset in the middle of a frame
        put(16'hFFFF);
        put(16'hBEEF);
        pcm_if.din_vld = 1'b0;
        repeat (30) tick();
        chk("t6.pre_busy", pcm_if.busy, 1);
        chk("t6.pre_level", pcm_if.level, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.busy", pcm_if.busy, 0);
        chk("t6.bclk", pcm_if.bclk, 0);
        chk("t6.sdata", pcm_if.sdata, 0);
        chk("t6.level", pcm_if.level, 0);
        tick();
        rst_n = 1'b1;
        errs = 0;
        for (int k = 0; k < 10; k++) begin
            if (pcm_if.busy !== 1'b0 || pcm_if.fs !== 1'b0 || pcm_if.sdata !== 1'b0) errs++;
            tick();
        end
        chk("t6.quiet", errs, 0);
        put(16'h3C5A);
        pcm_if.din_vld = 1'b0;
        tick();
        run_frame("t6a", 16'h3C5A, 0);
        chk("t6.idle", pcm_if.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lms_pcm_tx.md
LMS_PCM_TX -- requirements
Module: lms_pcm_tx

Interface
REQ-001 Parameter W, default 16: sample width in bits.
REQ-002 Parameter DEPTH, default 4: sample FIFO depth; power of two, at least 2.
REQ-003 Parameter CLKDIV, default 4: clk cycles per serial bit; even, at least 2.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  frame-start enable; low blocks new frames only.
REQ-007 din  input  W  filtered sample (LMS err/yout), two's complement.
REQ-008 din_vld  input  1  one-cycle write strobe for din.
REQ-009 clr_ovf  input  1  clears the sticky overflow flag.
REQ-010 bclk  output  1  serial bit clock.
REQ-011 sdata  output  1  serial data, MSB first.
REQ-012 fs  output  1  frame sync, high during the MSB bit period.
REQ-013 busy  output  1  high while a frame is being shifted.
REQ-014 ovf  output  1  sticky: a write was dropped because the FIFO was full.
REQ-015 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 FIFO write: din_vld=1 and not full pushes din at the clock edge.
REQ-017 FIFO write when full: the sample is dropped and ovf is set to 1 at that edge.
  - If a pop occurs in the same cycle, the FIFO is not full and the write is accepted.
REQ-018 ovf holds until clr_ovf=1; if clr_ovf and a new overflow occur together, ovf stays 1.
REQ-019 FSM has two states, IDLE and SHIFT; all outputs are registered.
REQ-020 IDLE->SHIFT when en=1 and level>0 at an edge:
  - pops the head sample into a W-bit shift register;
  - resets the bit-period counter and bit index;
  - from the next cycle: busy=1, fs=1, sdata=sample MSB.
REQ-021 A sample written at edge t into an empty FIFO, with the FSM in IDLE and en=1, appears on sdata from edge t+1 (pop at t+1); first-bit latency is 1 cycle after acceptance.
REQ-022 Bit-period counter cycles 0..CLKDIV-1.
  - bclk=0 for counts 0..CLKDIV/2-1 and 1 for the rest.
  - sdata changes only when the count wraps to 0.
REQ-023 fs=1 exactly for bit index 0, i.e. CLKDIV cycles per frame.
REQ-024 The frame lasts W*CLKDIV cycles; bits are sent in order W-1 down to 0.
REQ-025 At the last cycle of bit 0:
  - if en=1 and level>0, pop and start the next frame with no gap (fs=1 on the next cycle);
  - otherwise go to IDLE.
REQ-026 In IDLE: bclk=0, sdata=0, fs=0, busy=0.
REQ-027 en falling during SHIFT does not abort the frame; the frame completes, then the FSM idles.
REQ-028 FIFO pointers wrap modulo DEPTH; level is never greater than DEPTH and never negative.
REQ-029 Sustained write rate above one sample per W*CLKDIV cycles drains into overflow; no sample is reordered or duplicated.

Reset
REQ-030 On rst_n=0, immediately and asynchronously:
  - FIFO emptied (level=0), FSM in IDLE;
  - bclk=0, sdata=0, fs=0, busy=0, ovf=0;
  - shift register and counters cleared.
REQ-031 Reset mid-frame truncates the frame; the first frame after release starts only on a new write.

Verification
REQ-032 Reset release, en=1, one write din=16'hA5C3 -> fs high for 4 cycles, then sdata=1010010111000011 MSB first, 4 cycles per bit, busy for 64 cycles, then IDLE.
REQ-033 Four writes 16'h8001, 16'h7FFE, 16'hFFFF, 16'h0000 on consecutive cycles -> four back-to-back frames, fs pulses exactly 64 cycles apart, level peaks at 3, no ovf.
REQ-034 Six writes in six consecutive cycles, DEPTH=4 -> level reaches 4, exactly one sample dropped (the 6th), ovf=1 until clr_ovf, then 5 frames total.
REQ-035 Full FIFO with a pop coinciding with a write -> write accepted, ovf stays 0, level unchanged.
REQ-036 en=0 with 2 queued samples -> no fs, busy=0; en raised -> frames start on the next edge; en dropped mid-frame -> that frame completes and no further frame starts.
REQ-037 rst_n pulsed low at bit 7 of a frame -> all outputs 0 immediately, level=0; after release, no output until the next write.
